// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter holds values up to DATA_WIDTH-1 without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock with a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed Overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic                  Overflow,
`endif
  output logic                  Borrow
);

  localparam int            CW   = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                  state, next_state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   work_a, work_b, work_diff;
  logic                    br;
  logic                    d, bout;
  logic                    last_bit;
  logic [DATA_WIDTH-1:0]   diff_next;
`ifdef SERIAL_SUB_OVF_EN
  logic                    a_msb, b_msb;
`endif

  full_subtractor u_cell (
    .a    (work_a[0]),
    .b    (work_b[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  assign last_bit  = (state == SHIFT) && (cnt == LAST);
  assign diff_next = {d, work_diff[DATA_WIDTH-1:1]};
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every register here, outputs included, is cleared by reset so an
  // interrupted operation can never leak a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      work_a    <= '0;
      work_b    <= '0;
      work_diff <= '0;
      br        <= 1'b0;
      Diff      <= '0;
      Borrow    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_a <= A;
            work_b <= B;
            br     <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= A[DATA_WIDTH-1];
            b_msb  <= B[DATA_WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          work_a    <= work_a >> 1;
          work_b    <= work_b >> 1;
          work_diff <= diff_next;
          br        <= bout;
          if (last_bit) begin
            Diff     <= diff_next;
            Borrow   <= bout;
`ifdef SERIAL_SUB_OVF_EN
            Overflow <= (a_msb != b_msb) && (diff_next[DATA_WIDTH-1] != a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
